// File: rtl/key_debouncer_pkg.sv
// Shared limits, counter sizing and edge encoding for the key debouncer.
package key_debouncer_pkg;

  localparam int CH_MIN     = 1;
  localparam int CH_MAX     = 32;
  localparam int STABLE_MIN = 2;
  localparam int STABLE_MAX = 65535;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  // Counter only has to reach STABLE_CYCLES-1, so $clog2 of the count is enough.
  function automatic int cnt_width(input int stable_cycles);
    int sc;
    sc = stable_cycles;
    if (sc < STABLE_MIN) begin
      sc = STABLE_MIN;
    end else if (sc > STABLE_MAX) begin
      sc = STABLE_MAX;
    end
    return $clog2(sc);
  endfunction

  function automatic bit cfg_valid(input int ch, input int stable_cycles);
    return (ch >= CH_MIN) && (ch <= CH_MAX) &&
           (stable_cycles >= STABLE_MIN) && (stable_cycles <= STABLE_MAX);
  endfunction

endpackage

// File: rtl/key_debouncer_channel.sv
// One debounced line: 2-flop synchronizer, qualification counter, accepted
// level and registered one-cycle rise/fall pulses.
module debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = 1000,
  parameter logic INIT_LEVEL    = 1'b1,
  parameter int   CNT_W         = cnt_width(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic data_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             st_q, st_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  edge_e            edge_s;

  // Qualification: any agreeing sample restarts the count; terminal count accepts.
  always_comb begin
    s1_d   = data_i;
    s2_d   = s1_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    edge_s = EDGE_NONE;
    if (s2_q == st_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (!sample_en) begin
      cnt_d = cnt_q;
    end else if (cnt_q == CNT_TERM) begin
      st_d   = s2_q;
      cnt_d  = {CNT_W{1'b0}};
      edge_s = s2_q ? EDGE_RISE : EDGE_FALL;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Edge decode into the pulse registers.
  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (edge_s)
      EDGE_RISE: rise_d = 1'b1;
      EDGE_FALL: fall_d = 1'b1;
      default: begin
        rise_d = 1'b0;
        fall_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset to the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= INIT_LEVEL;
      s2_q   <= INIT_LEVEL;
      st_q   <= INIT_LEVEL;
      cnt_q  <= {CNT_W{1'b0}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = st_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel key debouncer: CH independent debounce_channel instances plus
// a registered any_change summary one cycle behind the edge pulses.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int   CH            = 4,
  parameter int   STABLE_CYCLES = 1000,
  parameter logic INIT_LEVEL    = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_en,
  input  logic [CH-1:0] data_in,
  output logic [CH-1:0] data_out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_change
);

  localparam int CNT_W     = cnt_width(STABLE_CYCLES);
  localparam bit CFG_VALID = cfg_valid(CH, STABLE_CYCLES);

  logic any_change_q, any_change_d;

  // Out-of-range configurations build an inert block parked at the idle level.
  generate
    if (CFG_VALID) begin : g_valid
      for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_channel #(
          .STABLE_CYCLES(STABLE_CYCLES),
          .INIT_LEVEL   (INIT_LEVEL),
          .CNT_W        (CNT_W)
        ) u_ch (
          .clk      (clk),
          .reset    (reset),
          .sample_en(sample_en),
          .data_i   (data_in[i]),
          .level_o  (data_out[i]),
          .rise_o   (rise[i]),
          .fall_o   (fall[i])
        );
      end
    end else begin : g_invalid
      assign data_out = {CH{INIT_LEVEL}};
      assign rise     = {CH{1'b0}};
      assign fall     = {CH{1'b0}};
    end
  endgenerate

  // Summary of all channel pulses in the current cycle.
  always_comb begin
    any_change_d = |(rise | fall);
  end

  // Summary register.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= any_change_d;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with CH=4, STABLE_CYCLES=4, INIT_LEVEL=1.
module tb_key_debouncer;

  localparam int CH = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_en;
  logic [CH-1:0] data_in;
  logic [CH-1:0] data_out;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          any_change;

  int checks = 0;
  int errors = 0;
  int rise_cnt;
  int fall_cnt;
  int run;

  always #5 clk = ~clk;

  key_debouncer #(
    .CH(CH),
    .STABLE_CYCLES(SC),
    .INIT_LEVEL(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    sample_en = 1'b1;
    data_in   = 4'hF;
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'hF);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_any", 32'(any_change), 32'h0);
    check("rst_cnt0", 32'(dut.g_valid.g_ch[0].u_ch.cnt_q), 32'h0);

    // Release with idle inputs: no pulses.
    reset = 1'b0;
    repeat (3) begin
      tick();
      check("post_rst_rise", 32'(rise), 32'h0);
      check("post_rst_fall", 32'(fall), 32'h0);
      check("post_rst_data", 32'(data_out), 32'hF);
    end

    // Held 1->0 on channel 0: accepted on the 6th edge (capture + 5).
    data_in = 4'hE;
    repeat (5) tick();
    check("ch0_early_data", 32'(data_out), 32'hF);
    check("ch0_early_fall", 32'(fall), 32'h0);
    tick();
    check("ch0_data", 32'(data_out), 32'hE);
    check("ch0_fall", 32'(fall), 32'h1);
    check("ch0_rise", 32'(rise), 32'h0);
    check("ch0_any_lag", 32'(any_change), 32'h0);
    tick();
    check("ch0_fall_end", 32'(fall), 32'h0);
    check("ch0_any", 32'(any_change), 32'h1);
    tick();
    check("ch0_any_end", 32'(any_change), 32'h0);

    // Channel 1 glitch: 3 cycles low is one sample short of acceptance.
    data_in = 4'hC;
    repeat (3) tick();
    data_in = 4'hE;
    repeat (6) begin
      tick();
      check("glitch_fall", 32'(fall), 32'h0);
      check("glitch_data", 32'(data_out), 32'hE);
    end
    check("glitch_cnt1", 32'(dut.g_valid.g_ch[1].u_ch.cnt_q), 32'h0);

    // Channel 0 back high with sample_en on odd edges only: accept at edge 9.
    data_in = 4'hF;
    for (int e = 1; e <= 9; e++) begin
      sample_en = (e % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      if (e == 6 || e == 8) begin
        check("slow_data_hold", 32'(data_out), 32'hE);
        check("slow_rise_hold", 32'(rise), 32'h0);
      end
    end
    check("slow_data", 32'(data_out), 32'hF);
    check("slow_rise", 32'(rise), 32'h1);
    sample_en = 1'b1;
    tick();
    check("slow_rise_end", 32'(rise), 32'h0);
    tick();

    // Channels 2 and 3 fall together, then rise together.
    data_in = 4'h3;
    repeat (5) tick();
    check("pair_fall_early", 32'(fall), 32'h0);
    tick();
    check("pair_fall", 32'(fall), 32'hC);
    check("pair_fall_rise", 32'(rise), 32'h0);
    check("pair_fall_data", 32'(data_out), 32'h3);
    tick();
    check("pair_fall_end", 32'(fall), 32'h0);
    check("pair_any", 32'(any_change), 32'h1);
    tick();
    check("pair_any_end", 32'(any_change), 32'h0);
    data_in = 4'hF;
    repeat (6) tick();
    check("pair_rise", 32'(rise), 32'hC);
    check("pair_rise_data", 32'(data_out), 32'hF);
    tick();
    check("pair_rise_any", 32'(any_change), 32'h1);
    tick();
    check("pair_rise_any_end", 32'(any_change), 32'h0);

    // Reset mid-qualification with count at 2.
    data_in = 4'hE;
    repeat (4) tick();
    check("mid_cnt0", 32'(dut.g_valid.g_ch[0].u_ch.cnt_q), 32'h2);
    reset   = 1'b1;
    data_in = 4'hF;
    repeat (2) tick();
    check("mid_rst_cnt0", 32'(dut.g_valid.g_ch[0].u_ch.cnt_q), 32'h0);
    reset = 1'b0;
    repeat (8) begin
      tick();
      check("mid_rise", 32'(rise), 32'h0);
      check("mid_fall", 32'(fall), 32'h0);
      check("mid_data", 32'(data_out), 32'hF);
    end

    // Bounce on channel 0: ten short runs, then settle low.
    rise_cnt = 0;
    fall_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      data_in[0] = ~data_in[0];
      run = int'($urandom_range(3, 1));
      repeat (run) begin
        tick();
        if (rise[0]) rise_cnt++;
        if (fall[0]) fall_cnt++;
        check("bounce_excl", 32'(rise & fall), 32'h0);
      end
    end
    data_in[0] = 1'b0;
    repeat (12) begin
      tick();
      if (rise[0]) rise_cnt++;
      if (fall[0]) fall_cnt++;
      check("bounce_excl", 32'(rise & fall), 32'h0);
    end
    check("bounce_fall_count", 32'(fall_cnt), 32'h1);
    check("bounce_rise_count", 32'(rise_cnt), 32'h0);
    check("bounce_data", 32'(data_out), 32'hE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent input channels (keypad lines), 1..32.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1000: consecutive qualifying samples required to accept a level change, 2..65535.
REQ-003 SHALL have parameter INIT_LEVEL, default 1'b1: idle level of every channel, applied at reset.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port sample_en, input, 1: qualifies counter advance (prescaler tick); tie high for per-clock sampling.
REQ-007 SHALL have port data_in, input, CH: raw asynchronous switch levels.
REQ-008 SHALL have port data_out, output, CH: debounced levels.
REQ-009 SHALL have port rise, output, CH: one-cycle pulse per channel on accepted 0->1.
REQ-010 SHALL have port fall, output, CH: one-cycle pulse per channel on accepted 1->0.
REQ-011 SHALL have port any_change, output, 1: registered OR of rise|fall, one cycle after those pulses.

Function
REQ-012 SHALL pass each data_in bit through a 2-flop synchronizer (s1, s2); s2 is the only value compared.
REQ-013 SHALL keep per channel a counter cnt of width $clog2(STABLE_CYCLES) and accepted state st (drives data_out).
REQ-014 SHALL clear cnt to 0 on any edge where s2 == st, regardless of sample_en.
REQ-015 SHALL increment cnt on an edge where s2 != st, sample_en == 1 and cnt < STABLE_CYCLES-1.
REQ-016 SHALL, on an edge where s2 != st, sample_en == 1 and cnt == STABLE_CYCLES-1, load st <= s2, clear cnt, and assert rise or fall (per new value) for exactly that one following cycle.
REQ-017 SHALL hold cnt unchanged on an edge where s2 != st and sample_en == 0.
REQ-018 SHALL, with sample_en constantly 1 and data_in changed before edge k and held, update data_out at edge k+STABLE_CYCLES+1.
REQ-019 SHALL reject any pulse/glitch whose synchronized width is shorter than STABLE_CYCLES qualifying samples: data_out, rise, fall unchanged, cnt returns to 0.
REQ-020 SHALL never let cnt wrap; the terminal value triggers REQ-016 instead.
REQ-021 SHALL treat channels fully independently; simultaneous acceptances on several channels SHALL produce simultaneous pulses and a single any_change pulse.
REQ-022 SHALL keep rise and fall mutually exclusive per channel in any cycle.

Reset
REQ-023 SHALL, while reset is high at an edge, set s1, s2, st to INIT_LEVEL on all channels, cnt to 0, rise/fall/any_change to 0.
REQ-024 SHALL produce no rise/fall pulse in the cycle after reset deassertion when data_in equals INIT_LEVEL.
REQ-025 SHALL abort any in-progress qualification on reset mid-count; no pulse from the aborted count.

Structure
REQ-026 SHALL place CH/STABLE_CYCLES limits and the counter-width constant in package key_debouncer_pkg.
REQ-027 SHALL implement one channel (sync, cnt, st, edge pulses) as sub-module debounce_channel, instantiated CH times by generate.
REQ-028 SHALL register all outputs; no combinational path data_in -> output.

Verification
REQ-029 SHALL test: CH=4, STABLE_CYCLES=4, INIT_LEVEL=1, data_in[0] 1->0 held -> data_out[0]=0 and fall[0]=1 for one cycle exactly 5 edges after first capture; other bits unchanged.
REQ-030 SHALL test: data_in[1] low for 3 cycles then high -> no fall[1], data_out[1] stays 1, cnt back to 0.
REQ-031 SHALL test: sample_en high every 2nd cycle, STABLE_CYCLES=4, held change -> data_out updates after 4 qualifying samples (approx 9 edges), not 5.
REQ-032 SHALL test: channels 2 and 3 change on same edge -> rise/fall on both same cycle, any_change high exactly one cycle, one cycle later.
REQ-033 SHALL test: reset asserted with cnt=2 mid-qualification -> after release no pulse, data_out=4'b1111.
REQ-034 SHALL test: bouncing input (10 random toggles shorter than 4 cycles, then stable 0) -> exactly one fall pulse, no rise.
